// File: rtl/spart_pkg.sv
// spart_pkg: spart bus addresses, baud divisors and driver state encoding
package spart_pkg;
    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;
    localparam logic [15:0] DIV_4800  = 16'd650;
    localparam logic [15:0] DIV_9600  = 16'd325;
    localparam logic [15:0] DIV_19200 = 16'd162;
    localparam logic [15:0] DIV_38400 = 16'd80;
    typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, RD_HOLD, WR, WR_HOLD} state_t;
endpackage

// File: rtl/spart_fifo.sv
// spart_fifo: circular byte buffer with combinational head output
module spart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/spart_driver.sv
// spart_driver: programs the spart baud divisor, then echoes received bytes through a FIFO
module spart_driver
    import spart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_4800   = spart_pkg::DIV_4800,
    parameter logic [15:0] DIV_9600   = spart_pkg::DIV_9600,
    parameter logic [15:0] DIV_19200  = spart_pkg::DIV_19200,
    parameter logic [15:0] DIV_38400  = spart_pkg::DIV_38400
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    input  logic                          rda,
    input  logic                          tbr,
    output logic                          iocs,
    output logic                          iorw,
    output logic [1:0]                    ioaddr,
    inout  wire  [7:0]                    databus,
    output logic                          cfg_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
    state_t state;
    logic [1:0] br_q, br_sel;
    logic [15:0] div;
    logic [7:0] wdata, head;
    logic full, empty;
    // CFG_LO samples br_cfg on the same edge that loads br_q
    assign br_sel  = (state == CFG_LO) ? br_cfg : br_q;
    assign div     = (br_sel == 2'd0) ? DIV_4800 :
                     (br_sel == 2'd1) ? DIV_9600 :
                     (br_sel == 2'd2) ? DIV_19200 : DIV_38400;
    assign databus = (iocs && !iorw) ? wdata : 8'hzz;
    spart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (state == RD),
        .pop   (state == WR),
        .din   (databus),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );
    // Bus outputs are registered: the edge leaving a state launches the next bus cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CFG_LO;
            iocs     <= 1'b0;
            iorw     <= 1'b1;
            ioaddr   <= ADDR_DATA;
            wdata    <= '0;
            cfg_done <= 1'b0;
            br_q     <= '0;
        end else begin
            iocs   <= 1'b0;
            iorw   <= 1'b1;
            ioaddr <= ADDR_DATA;
            case (state)
                CFG_LO: begin
                    br_q   <= br_cfg;
                    iocs   <= 1'b1;
                    iorw   <= 1'b0;
                    ioaddr <= ADDR_DBL;
                    wdata  <= div[7:0];
                    state  <= CFG_HI;
                end
                CFG_HI: begin
                    iocs   <= 1'b1;
                    iorw   <= 1'b0;
                    ioaddr <= ADDR_DBH;
                    wdata  <= div[15:8];
                    state  <= IDLE;
                end
                IDLE: begin
                    cfg_done <= 1'b1;
                    if (br_cfg != br_q) begin
                        br_q     <= br_cfg;
                        cfg_done <= 1'b0;
                        state    <= CFG_LO;
                    end else if (rda && !full) begin
                        iocs  <= 1'b1;
                        state <= RD;
                    end else if (tbr && !empty) begin
                        iocs  <= 1'b1;
                        iorw  <= 1'b0;
                        wdata <= head;
                        state <= WR;
                    end
                end
                RD:      state <= RD_HOLD;
                WR:      state <= WR_HOLD;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: randomized echo traffic checked against a transaction-level spart/driver model
module tb_spart_driver;
    localparam int DEPTH = 8;
    logic clk = 0, rst = 0;
    logic [1:0] br_cfg = 2'd1;
    logic rda = 0, tbr = 0;
    logic iocs, iorw, cfg_done;
    logic [1:0] ioaddr;
    logic [3:0] fifo_cnt;
    logic [7:0] tb_data = 0;
    wire  [7:0] databus;
    assign databus = (iocs && iorw) ? tb_data : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (databus[i]);
    end
    spart_driver #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .rda      (rda),
        .tbr      (tbr),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .cfg_done (cfg_done),
        .fifo_cnt (fifo_cnt)
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0, cyc = 0, phase = 0, next_ok = 0, cfg_cnt = 0;
    logic done_m = 0, rda_en = 1, tbr_en = 0, rd_hit;
    logic [1:0] brq_m = 0;
    logic [7:0] lo_seen = 0, hi_seen = 0, b;
    logic [15:0] dv;
    logic [7:0] rx_q[$], fifo_q[$], tx_log[$], acc_log[$], sent[$];
    function automatic logic [15:0] div_of(input logic [1:0] s);
        return s == 2'd0 ? 16'd650 : s == 2'd1 ? 16'd325 : s == 2'd2 ? 16'd162 : 16'd80;
    endfunction
    task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask
    task automatic tick;
        @(negedge clk);
        #1;
    endtask
    task automatic wait_cfg(input int n0, input string nm);
        for (int i = 0; i < 60 && !(cfg_cnt > n0 && phase == 2 && done_m); i++) tick;
        chk(nm, 16'(cfg_done), 16'd1);
    endtask
    // Model: configuration pair, then greedy transfers at least 3 cycles apart
    always @(negedge clk) begin
        cyc++;
        rd_hit = 0;
        if (!rst) begin
            fifo_q.delete();
            phase  = 0;
            done_m = 0;
            chk("rst_iocs", 16'(iocs), 16'd0);
            chk("rst_cfg_done", 16'(cfg_done), 16'd0);
            chk("rst_cnt", 16'(fifo_cnt), 16'd0);
            chk("rst_bus_z", 16'(databus), 16'h00ff);
        end else begin
            chk("fifo_cnt", 16'(fifo_cnt), 16'(fifo_q.size()));
            if (!iocs) chk("bus_z", 16'(databus), 16'h00ff);
            if (phase == 0) begin
                dv = div_of(br_cfg);
                brq_m = br_cfg;
                chk("lo_cyc", 16'({iocs, iorw, ioaddr}), 16'b1010);
                chk("lo_data", 16'(databus), 16'(dv[7:0]));
                lo_seen = databus;
                phase = 1;
            end else if (phase == 1) begin
                dv = div_of(brq_m);
                chk("hi_cyc", 16'({iocs, iorw, ioaddr}), 16'b1011);
                chk("hi_data", 16'(databus), 16'(dv[15:8]));
                hi_seen = databus;
                cfg_cnt++;
                phase = 2;
                next_ok = cyc + 1;
            end else if (cyc < next_ok) begin
                chk("hold_idle", 16'(iocs), 16'd0);
            end else if (br_cfg != brq_m) begin
                chk("brchg_idle", 16'(iocs), 16'd0);
                done_m = 0;
                phase = 0;
            end else begin
                done_m = 1;
                if (rda && fifo_q.size() < DEPTH) begin
                    chk("rd_cyc", 16'({iocs, iorw, ioaddr}), 16'b1100);
                    fifo_q.push_back(tb_data);
                    void'(rx_q.pop_front());
                    acc_log.push_back("R");
                    rd_hit = 1;
                    next_ok = cyc + 3;
                end else if (tbr && fifo_q.size() > 0) begin
                    chk("wr_cyc", 16'({iocs, iorw, ioaddr}), 16'b1000);
                    chk("wr_data", 16'(databus), 16'(fifo_q[0]));
                    tx_log.push_back(fifo_q.pop_front());
                    acc_log.push_back("W");
                    next_ok = cyc + 3;
                end else begin
                    chk("idle", 16'(iocs), 16'd0);
                    next_ok = cyc + 1;
                end
            end
            chk("cfg_done", 16'(cfg_done), 16'(done_m));
        end
        tb_data = rd_hit ? tb_data : (rx_q.size() > 0 ? rx_q[0] : 8'h00);
        rda = rda_en && rx_q.size() > 0;
        tbr = tbr_en;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
    initial begin
        int n;
        repeat (3) tick;
        rst = 1;
        wait_cfg(0, "t1_cfg");
        chk("t1_lo", 16'(lo_seen), 16'h0045);
        chk("t1_hi", 16'(hi_seen), 16'h0001);
        tx_log.delete();
        tbr_en = 1;
        rx_q.push_back(8'h41);
        for (int i = 0; i < 30 && tx_log.size() < 1; i++) tick;
        chk("t2_echo", tx_log.size() > 0 ? 16'(tx_log[0]) : 16'hdead, 16'h0041);
        repeat (4) tick;
        chk("t2_single", 16'(tx_log.size()), 16'd1);
        tbr_en = 0;
        tx_log.delete();
        for (int i = 0; i < 9; i++) rx_q.push_back(8'(8'h60 + i));
        repeat (40) tick;
        chk("t3_cnt", 16'(fifo_cnt), 16'd8);
        chk("t3_left", 16'(rx_q.size()), 16'd1);
        acc_log.delete();
        tbr_en = 1;
        for (int i = 0; i < 200 && tx_log.size() < 9; i++) tick;
        chk("t4_full_wr_first", acc_log.size() > 0 ? 16'(acc_log[0]) : 16'h0, 16'("W"));
        for (int i = 0; i < 9; i++)
            chk("t3_order", i < tx_log.size() ? 16'(tx_log[i]) : 16'hdead, 16'(8'h60 + i));
        tbr_en = 0;
        tx_log.delete();
        rx_q.push_back(8'ha0);
        rx_q.push_back(8'ha1);
        repeat (12) tick;
        acc_log.delete();
        rx_q.push_back(8'ha2);
        tbr_en = 1;
        for (int i = 0; i < 60 && tx_log.size() < 3; i++) tick;
        chk("t4_rd_first", acc_log.size() > 0 ? 16'(acc_log[0]) : 16'h0, 16'("R"));
        for (int i = 0; i < 3; i++)
            chk("t4_order", i < tx_log.size() ? 16'(tx_log[i]) : 16'hdead, 16'(8'ha0 + i));
        tbr_en = 0;
        tx_log.delete();
        for (int i = 0; i < 3; i++) rx_q.push_back(8'(8'hb0 + i));
        repeat (12) tick;
        n = cfg_cnt;
        br_cfg = 2'd3;
        wait_cfg(n, "t5_cfg");
        chk("t5_lo", 16'(lo_seen), 16'h0050);
        chk("t5_hi", 16'(hi_seen), 16'h0000);
        chk("t5_kept", 16'(fifo_cnt), 16'd3);
        tbr_en = 1;
        for (int i = 0; i < 60 && tx_log.size() < 3; i++) tick;
        for (int i = 0; i < 3; i++)
            chk("t5_order", i < tx_log.size() ? 16'(tx_log[i]) : 16'hdead, 16'(8'hb0 + i));
        tbr_en = 0;
        for (int i = 0; i < 4; i++) rx_q.push_back(8'(8'hc0 + i));
        repeat (15) tick;
        tbr_en = 1;
        for (int i = 0; i < 40 && !(iocs && !iorw); i++) begin
            @(posedge clk);
            #2;
        end
        chk("t6_in_wr", 16'(iocs && !iorw), 16'd1);
        rda_en = 0;
        rst = 0;
        #1;
        chk("t6_iocs", 16'(iocs), 16'd0);
        chk("t6_bus_z", 16'(databus), 16'h00ff);
        repeat (2) tick;
        rx_q.delete();
        n = cfg_cnt;
        rst = 1;
        wait_cfg(n, "t6_cfg");
        chk("t6_lo", 16'(lo_seen), 16'h0050);
        chk("t6_empty", 16'(fifo_cnt), 16'd0);
        tx_log.delete();
        for (int k = 0; k < 1500; k++) begin
            rda_en = $urandom_range(0, 3) != 0;
            tbr_en = $urandom_range(0, 2) != 0;
            if (rx_q.size() < 4 && $urandom_range(0, 1) == 1) begin
                b = 8'($urandom);
                rx_q.push_back(b);
                sent.push_back(b);
            end
            if ($urandom_range(0, 199) == 0) br_cfg = 2'($urandom_range(0, 3));
            tick;
        end
        rda_en = 1;
        tbr_en = 1;
        for (int i = 0; i < 600 && (rx_q.size() > 0 || fifo_q.size() > 0 || phase != 2); i++) tick;
        chk("rand_count", 16'(tx_log.size()), 16'(sent.size()));
        for (int i = 0; i < sent.size(); i++)
            chk("rand_data", i < tx_log.size() ? 16'(tx_log[i]) : 16'hdead, 16'(sent[i]));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
